down_timer: RTL and testbench



---
 rtl/down_timer_if.sv | 26 ++
 rtl/down_timer.sv | 76 +++++++
 tb/tb_down_timer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/down_timer_if.sv
// Signal bundle between a controller and the down_timer block.
// The controller drives load/enab/cnt_in; the timer returns count and status.
interface down_timer_if #(
    parameter int WIDTH = 5
) ();
    // No valid/ready pair here: load and enab are level-sampled on every rising
    // edge, cnt_in matters only on edges with load high, and every output is
    // meaningful on every cycle.
    logic             load;
    logic             enab;
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] cnt_out;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output load, enab, cnt_in,
        input  cnt_out, busy, done, zero
    );

    modport slave (
        input  load, enab, cnt_in,
        output cnt_out, busy, done, zero
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with a one-cycle done pulse on expiry.
// Define DOWN_TIMER_AUTO_RELOAD_EN for periodic operation from a reload register.
module down_timer #(
    parameter int WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    down_timer_if.slave  tmr,
    output logic         dbg_state_o
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        if (tmr.load) begin
            // A load always wins, so a restart on the expiry edge suppresses done.
            cnt_d   = tmr.cnt_in;
            state_d = (tmr.cnt_in != '0) ? RUN : IDLE;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
            reload_d = tmr.cnt_in;
`endif
        end else if (tmr.enab && (state_q == RUN)) begin
            if (cnt_q > WIDTH'(1)) begin
                cnt_d = cnt_q - WIDTH'(1);
            end else if (cnt_q == WIDTH'(1)) begin
                done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                cnt_d   = reload_q;
                state_d = RUN;
`else
                cnt_d   = '0;
                state_d = IDLE;
`endif
            end
        end
    end

    assign tmr.cnt_out = cnt_q;
    assign tmr.busy    = (state_q == RUN);
    assign tmr.done    = done_q;
    assign tmr.zero    = (cnt_q == '0);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_down_timer.sv
// Directed vector bench for down_timer; expectations follow the build's
// DOWN_TIMER_AUTO_RELOAD_EN setting.
module tb_down_timer;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;

  always #5 clk = ~clk;

  down_timer_if #(.WIDTH(W)) tif ();

  down_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .tmr         (tif.slave),
    .dbg_state_o (dbg_state)
  );

  typedef struct {
    logic         rst;
    logic         load;
    logic         enab;
    logic [W-1:0] cnt_in;
    logic [W-1:0] exp_cnt;
    logic         exp_busy;
    logic         exp_done;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  function automatic void add(input logic r, input logic l, input logic e,
                              input int ci, input int ec, input logic eb,
                              input logic ed, input logic ez);
    vec_t v;
    v.rst = r; v.load = l; v.enab = e; v.cnt_in = W'(ci);
    v.exp_cnt = W'(ec); v.exp_busy = eb; v.exp_done = ed; v.exp_zero = ez;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d exp=%0d", nm, idx, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic e, input logic [W-1:0] ci);
    @(negedge clk);
    rst = r; tif.load = l; tif.enab = e; tif.cnt_in = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int idx, input int ec,
                            input logic eb, input logic ed, input logic ez);
    chk({tag, ".cnt_out"}, idx, int'(tif.cnt_out), ec);
    chk({tag, ".busy"},    idx, int'(tif.busy), int'(eb));
    chk({tag, ".done"},    idx, int'(tif.done), int'(ed));
    chk({tag, ".zero"},    idx, int'(tif.zero), int'(ez));
    chk({tag, ".state"},   idx, int'(dbg_state), int'(eb));
  endtask

  initial begin
    rst = 1'b1; tif.load = 1'b1; tif.enab = 1'b1; tif.cnt_in = W'(7);

    // rst load enab cnt_in | cnt busy done zero
    add(1, 1, 1, 7,   0, 0, 0, 1);
    add(1, 1, 1, 7,   0, 0, 0, 1);
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    add(0, 1, 0, 3,   3, 1, 0, 0);
    add(0, 0, 1, 9,   2, 1, 0, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0);
    add(0, 0, 1, 9,   3, 1, 1, 0);
    add(0, 0, 1, 0,   2, 1, 0, 0);
    add(0, 0, 1, 9,   1, 1, 0, 0);
    add(0, 0, 1, 0,   3, 1, 1, 0);
    add(0, 0, 1, 9,   2, 1, 0, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0);
    add(0, 0, 1, 9,   3, 1, 1, 0);
    add(0, 0, 1, 0,   2, 1, 0, 0);
    add(0, 0, 0, 5,   2, 1, 0, 0);
    add(0, 1, 1, 0,   0, 0, 0, 1);
    add(0, 0, 1, 0,   0, 0, 0, 1);
    add(0, 1, 0, 1,   1, 1, 0, 0);
    add(0, 0, 1, 0,   1, 1, 1, 0);
    add(0, 0, 1, 0,   1, 1, 1, 0);
    add(0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 0, 1, 0,   1, 1, 1, 0);
    add(1, 0, 1, 0,   0, 0, 0, 1);
    add(0, 0, 1, 0,   0, 0, 0, 1);
`else
    add(0, 1, 0, 3,   3, 1, 0, 0);
    add(0, 0, 1, 9,   2, 1, 0, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0);
    add(0, 0, 1, 9,   0, 0, 1, 1);
    add(0, 0, 1, 0,   0, 0, 0, 1);
    add(0, 0, 1, 6,   0, 0, 0, 1);
    add(0, 1, 0, 4,   4, 1, 0, 0);
    add(0, 0, 1, 0,   3, 1, 0, 0);
    add(0, 0, 0, 0,   3, 1, 0, 0);
    add(0, 0, 0, 0,   3, 1, 0, 0);
    add(0, 0, 1, 0,   2, 1, 0, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0);
    add(0, 0, 0, 0,   1, 1, 0, 0);
    add(0, 0, 1, 0,   0, 0, 1, 1);
    add(0, 0, 0, 0,   0, 0, 0, 1);
    add(0, 1, 0, 2,   2, 1, 0, 0);
    add(0, 0, 1, 0,   1, 1, 0, 0);
    add(0, 1, 1, 5,   5, 1, 0, 0);
    add(0, 0, 0, 0,   5, 1, 0, 0);
    add(0, 1, 1, 0,   0, 0, 0, 1);
    add(0, 0, 1, 0,   0, 0, 0, 1);
    add(0, 1, 1, 0,   0, 0, 0, 1);
    add(0, 1, 0, 12, 12, 1, 0, 0);
    add(0, 0, 1, 0,  11, 1, 0, 0);
    add(0, 0, 1, 0,  10, 1, 0, 0);
    add(1, 0, 1, 0,   0, 0, 0, 1);
    add(0, 0, 1, 0,   0, 0, 0, 1);
`endif

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].load, vecs[i].enab, vecs[i].cnt_in);
      check_outs("vec", i, int'(vecs[i].exp_cnt), vecs[i].exp_busy,
                 vecs[i].exp_done, vecs[i].exp_zero);
    end

    // Maximum load counts fully: done only after the 31st enabled edge,
    // with random enable gaps and random cnt_in on non-load edges.
    begin
      int k;
      int ec;
      logic eb;
      step(1'b0, 1'b1, 1'b0, W'(31));
      check_outs("max_load", 0, 31, 1'b1, 1'b0, 1'b0);
      k = 0;
      while (k < 31) begin
        logic e;
        e = ($urandom_range(0, 3) != 0);
        step(1'b0, 1'b0, e, W'($urandom_range(0, 31)));
        if (e) k++;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
        ec = (k == 31) ? 31 : 31 - k;
        eb = 1'b1;
`else
        ec = 31 - k;
        eb = (k < 31);
`endif
        check_outs("max_edge", k, ec, eb, e && (k == 31), ec == 0);
      end
      step(1'b0, 1'b0, 1'b0, W'(0));
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
      check_outs("max_after", 0, 31, 1'b1, 1'b0, 1'b0);
`else
      check_outs("max_after", 0, 0, 1'b0, 1'b0, 1'b1);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end
endmodule
